// File: rtl/vector_addsub_seq_pkg.sv
// ---------------------------------------------------------------------------
// vector_addsub_seq_pkg
// Purpose : Shared definitions for the sequential FP32 vector add/subtract.
//           It holds the FSM state encoding, the FP32 field constants and
//           the single-precision adder used by each lane.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package vector_addsub_seq_pkg;

    localparam int FP_W     = 32;
    localparam int SIGN_BIT = 31;
    localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // IEEE-754 single-precision add with round-to-nearest-even.
    // Subnormals are handled by giving them an effective exponent of 1 and
    // no hidden bit. Exact cancellation yields +0.
    function automatic logic [FP_W-1:0] fp32_add(input logic [FP_W-1:0] a,
                                                 input logic [FP_W-1:0] b);
        logic [FP_W-1:0] x, y, res;
        logic            a_nan, b_nan, a_inf, b_inf;
        logic [9:0]      ex, ey, d, e;
        logic [26:0]     mx, my;
        logic [27:0]     s;
        logic [24:0]     mr;
        logic            sticky, rnd;

        a_nan = (&a[30:23]) &  (|a[22:0]);
        b_nan = (&b[30:23]) &  (|b[22:0]);
        a_inf = (&a[30:23]) & ~(|a[22:0]);
        b_inf = (&b[30:23]) & ~(|b[22:0]);

        // x is always the operand of larger magnitude
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end

        ex = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
        ey = (y[30:23] == 8'd0) ? 10'd1 : {2'b00, y[30:23]};
        // hidden bit, 23 fraction bits, guard/round/sticky
        mx = {|x[30:23], x[22:0], 3'b000};
        my = {|y[30:23], y[22:0], 3'b000};

        d = ex - ey;
        if (d >= 10'd27) begin
            sticky = |my;
            my     = '0;
        end else begin
            sticky = |(my & ~({27{1'b1}} << d));
            my     = my >> d;
        end
        my[0] = my[0] | sticky;

        e = ex;
        if (x[SIGN_BIT] == y[SIGN_BIT]) begin
            s = {1'b0, mx} + {1'b0, my};
            if (s[27]) begin
                s = {1'b0, s[27:2], s[1] | s[0]};
                e = e + 10'd1;
            end
        end else begin
            s = {1'b0, mx - my};
            // normalise left, but never below the subnormal exponent
            for (int i = 0; i < 26; i++) begin
                if (!s[26] && (e > 10'd1)) begin
                    s = s << 1;
                    e = e - 10'd1;
                end
            end
        end

        rnd = s[2] & (s[1] | s[0] | s[3]);
        mr  = {1'b0, s[26:3]} + {24'd0, rnd};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'd1;
        end

        if (a_nan || b_nan || (a_inf && b_inf && (a[SIGN_BIT] ^ b[SIGN_BIT])))
            res = QNAN;
        else if (a_inf)
            res = a;
        else if (b_inf)
            res = b;
        else if (s == 28'd0)
            res = {x[SIGN_BIT] & y[SIGN_BIT], 31'd0};
        else if (e >= 10'd255)
            res = {x[SIGN_BIT], 8'hFF, 23'd0};
        else
            res = {x[SIGN_BIT], (mr[23] ? e[7:0] : 8'd0), mr[22:0]};
        return res;
    endfunction

endpackage

// File: rtl/vector_addsub_seq_lanes.sv
// ---------------------------------------------------------------------------
// vector_addsub_seq_lanes
// Purpose : Combinational element-wise FP32 vector adder, one adder per
//           element. Used by the sequential top as its LANES-wide datapath.
// Ports   : i_a   [FP_W*VLEN] operand vector, element i at [32*i +: 32]
//           i_b   [FP_W*VLEN] operand vector, same packing
//           o_sum [FP_W*VLEN] element-wise i_a + i_b
// ---------------------------------------------------------------------------
module vector_addsub_seq_lanes
    import vector_addsub_seq_pkg::*;
#(
    parameter int VLEN = 2
) (
    input  logic [FP_W*VLEN-1:0] i_a,
    input  logic [FP_W*VLEN-1:0] i_b,
    output logic [FP_W*VLEN-1:0] o_sum
);

    genvar gi;
    generate
        for (gi = 0; gi < VLEN; gi++) begin : g_lane
            assign o_sum[gi*FP_W +: FP_W] = fp32_add(i_a[gi*FP_W +: FP_W],
                                                     i_b[gi*FP_W +: FP_W]);
        end
    endgenerate

endmodule

// File: rtl/vector_addsub_seq.sv
// ---------------------------------------------------------------------------
// vector_addsub_seq
// Purpose : Multi-cycle FP32 vector add/subtract. An accepted operation is
//           buffered, then processed LANES elements per cycle over NCHUNK
//           cycles, and the full result is presented with valid/ready.
// Ports   : clk        system clock, rising edge
//           rst_n      asynchronous active-low reset
//           in_valid   A, B, sub valid
//           in_ready   high only in IDLE
//           A, B       [32*VLEN] operand vectors, element i at [32*i +: 32]
//           sub        0: A+B, 1: A-B
//           out_valid  high in DONE, result holds a complete vector
//           out_ready  consumer accepts result
//           result     [32*VLEN] result vector, same packing
// ---------------------------------------------------------------------------
module vector_addsub_seq
    import vector_addsub_seq_pkg::*;
#(
    parameter int VLEN  = 8,
    parameter int LANES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FP_W*VLEN-1:0] A,
    input  logic [FP_W*VLEN-1:0] B,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FP_W*VLEN-1:0] result
);

    localparam int NCHUNK = VLEN / LANES;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    generate
        if ((LANES < 1) || (LANES > VLEN) || ((VLEN % LANES) != 0)) begin : g_param_check
            $error("vector_addsub_seq: VLEN must be a non-zero multiple of LANES");
        end
    endgenerate

    state_t                r_state, w_state_next;
    logic [CW-1:0]         r_cnt, w_cnt_next;
    logic                  w_load;
    logic [FP_W*VLEN-1:0]  r_a, r_b;
    logic                  r_sub;
    logic [FP_W-1:0]       r_result [VLEN];
    logic [FP_W*LANES-1:0] w_a_chunk, w_b_chunk, w_sum;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // wrap to zero on the last chunk so the counter never
                // holds a value past NCHUNK-1
                if (r_cnt == LAST_CHUNK) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_DONE;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- operand buffers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sub <= 1'b0;
        end else if (w_load) begin
            r_a   <= A;
            r_b   <= B;
            r_sub <= sub;
        end
    end

    // ---------------- chunk mux ----------------
    // Lane gi of chunk k works on element k*LANES+gi. Subtraction is a sign
    // flip of B ahead of the adder, applied to every encoding.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_mux
            logic [FP_W-1:0] w_b_elem;
            assign w_a_chunk[gi*FP_W +: FP_W] = r_a[(int'(r_cnt)*LANES + gi)*FP_W +: FP_W];
            assign w_b_elem                   = r_b[(int'(r_cnt)*LANES + gi)*FP_W +: FP_W];
            assign w_b_chunk[gi*FP_W +: FP_W] = {w_b_elem[SIGN_BIT] ^ r_sub,
                                                 w_b_elem[SIGN_BIT-1:0]};
        end
    endgenerate

    vector_addsub_seq_lanes #(
        .VLEN (LANES)
    ) u_lanes (
        .i_a   (w_a_chunk),
        .i_b   (w_b_chunk),
        .o_sum (w_sum)
    );

    // ---------------- result registers ----------------
    // Each element is written only in the RUN cycle of its own chunk, so
    // the result is left untouched in IDLE and DONE.
    generate
        for (gi = 0; gi < VLEN; gi++) begin : g_res
            localparam logic [CW-1:0] CHUNK = CW'(gi / LANES);
            localparam int            LANE  = gi % LANES;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_result[gi] <= '0;
                else if ((r_state == ST_RUN) && (r_cnt == CHUNK))
                    r_result[gi] <= w_sum[LANE*FP_W +: FP_W];
            end

            assign result[gi*FP_W +: FP_W] = r_result[gi];
        end
    endgenerate

endmodule
